// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// fetch_unit_pkg: shared widths, fetch FSM encodings and the buffered entry type.
// Rev 1.0
package fetch_unit_pkg;
  localparam int ADDRESS_SIZE     = 16;
  localparam int INSTRUCTION_SIZE = 32;

  localparam logic [0:0] FETCH_RUN      = 1'b0;
  localparam logic [0:0] FETCH_REDIRECT = 1'b1;

  typedef struct packed {
    logic [ADDRESS_SIZE-1:0]     addr;
    logic [INSTRUCTION_SIZE-1:0] word;
  } fetch_entry_t;
endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// fetch_fifo: DEPTH-entry {addr, word} queue with synchronous clear and count/full/empty.
// Rev 1.0
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full queue may still accept a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: in-order prefetch from variable-latency program memory, presenting the word for pc.
// Rev 1.0
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [ADDRESS_SIZE-1:0]     pc,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic                        instr_valid,
  output logic                        mem_req,
  output logic [ADDRESS_SIZE-1:0]     mem_addr,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [INSTRUCTION_SIZE-1:0] mem_rdata
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDRESS_SIZE-1:0] ADDR_ONE = 1;

  logic [0:0]              state;
  logic [0:0]              state_next;
  logic [ADDRESS_SIZE-1:0] fetch_addr;
  logic [ADDRESS_SIZE-1:0] resp_addr;
  logic [ADDRESS_SIZE-1:0] head_addr;
  logic [CW-1:0]           inflight;
  logic [CW-1:0]           discard;
  logic [CW-1:0]           count;
  logic [CW:0]             pending;
  logic                    full;
  logic                    empty;
  fetch_entry_t            head;
  fetch_entry_t            push_data;
  logic                    resp;
  logic                    xfer;
  logic                    match;
  logic                    mismatch;
  logic                    dropping;
  logic                    bypass;
  logic                    pop;
  logic                    push;
  logic                    clear;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp      = mem_rvalid && (inflight != '0);
  assign dropping  = resp && (discard != '0);
  assign head_addr = empty ? resp_addr : head.addr;
  assign pending   = {1'b0, count} + {1'b0, inflight};
  assign match     = (pc == head_addr);
  assign mismatch  = (!match && (!empty || inflight != '0)) ||
                     (empty && inflight == '0 && fetch_addr != pc);
  assign xfer      = mem_req && mem_ready;
  assign push_data = {resp_addr, mem_rdata};
  assign push      = !reset && (state == FETCH_RUN) && resp && !dropping && !bypass;
  assign clear     = (state == FETCH_REDIRECT);

  always_ff @(posedge clock) begin
    if (reset) state <= FETCH_RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH_RUN: if (mismatch) state_next = FETCH_REDIRECT;
      default:   state_next = FETCH_RUN;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    instr_valid = 1'b0;
    pop         = 1'b0;
    bypass      = 1'b0;
    if (!reset && state == FETCH_RUN) begin
      mem_req = !full && (pending < (CW+1)'(DEPTH));
      if (match && !mismatch) begin
        if (!empty) begin
          instr_valid = 1'b1;
          pop         = 1'b1;
        end else if (resp && discard == '0) begin
          instr_valid = 1'b1;
          bypass      = 1'b1;
        end
      end
    end
  end

  assign mem_addr    = mem_req ? fetch_addr : '0;
  assign instruction = !instr_valid ? '0 : (bypass ? mem_rdata : head.word);

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_addr <= '0;
      resp_addr  <= '0;
      inflight   <= '0;
      discard    <= '0;
    end else if (state == FETCH_REDIRECT) begin
      // Everything still outstanding belongs to the old stream; a response this cycle is dropped now.
      fetch_addr <= pc;
      resp_addr  <= pc;
      inflight   <= inflight - CW'(resp);
      discard    <= inflight - CW'(resp);
    end else begin
      if (xfer) fetch_addr <= fetch_addr + ADDR_ONE;
      inflight <= inflight + CW'(xfer) - CW'(resp);
      if (dropping)  discard   <= discard - CW'(1);
      else if (resp) resp_addr <= resp_addr + ADDR_ONE;
    end
  end
endmodule
`default_nettype wire
